// File: rtl/id_ex_pipe_ctrl_if.sv
// ID/EX stage bus: decoded ID fields in, registered EX copies out, plus
// the hazard and trap side-band signals.
//
// Handshake: trap_req is a level held high from the cycle after an invalid
// instruction is accepted until the edge where trap_ack=1 is sampled; the
// trap is consumed on that edge and trap_req drops in the following cycle.
// load_use_stall is a same-cycle request for IF/ID to hold its contents.
interface id_ex_pipe_ctrl_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [2:0]            id_func3;
  logic [6:0]            id_func7;
  logic                  id_alu_src;
  logic                  id_mem_write;
  logic [2:0]            id_mem_load_type;
  logic [1:0]            id_mem_store_type;
  logic                  id_mem_read;
  logic                  id_wb_reg_file;
  logic                  id_invalid_inst;
  logic                  flush;
  logic                  stall_ext;
  logic                  trap_ack;

  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [REG_ADDR_W-1:0] ex_rs1_addr;
  logic [REG_ADDR_W-1:0] ex_rs2_addr;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [XLEN-1:0]       ex_imm;
  logic [2:0]            ex_func3;
  logic [6:0]            ex_func7;
  logic                  ex_alu_src;
  logic                  ex_mem_write;
  logic [2:0]            ex_mem_load_type;
  logic [1:0]            ex_mem_store_type;
  logic                  ex_mem_read;
  logic                  ex_wb_reg_file;
  logic                  load_use_stall;
  logic                  trap_req;
  logic [XLEN-1:0]       trap_pc;

  // Upstream / environment side
  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data,
           id_rs2_data, id_imm, id_func3, id_func7, id_alu_src, id_mem_write,
           id_mem_load_type, id_mem_store_type, id_mem_read, id_wb_reg_file,
           id_invalid_inst, flush, stall_ext, trap_ack,
    input  ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data,
           ex_rs2_data, ex_imm, ex_func3, ex_func7, ex_alu_src, ex_mem_write,
           ex_mem_load_type, ex_mem_store_type, ex_mem_read, ex_wb_reg_file,
           load_use_stall, trap_req, trap_pc
  );

  // Pipeline-register side
  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data,
           id_rs2_data, id_imm, id_func3, id_func7, id_alu_src, id_mem_write,
           id_mem_load_type, id_mem_store_type, id_mem_read, id_wb_reg_file,
           id_invalid_inst, flush, stall_ext, trap_ack,
    output ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data,
           ex_rs2_data, ex_imm, ex_func3, ex_func7, ex_alu_src, ex_mem_write,
           ex_mem_load_type, ex_mem_store_type, ex_mem_read, ex_wb_reg_file,
           load_use_stall, trap_req, trap_pc
  );
endinterface

// File: rtl/id_ex_pipe_ctrl.sv
// ID/EX pipeline register with load-use bubble insertion, external stall,
// branch flush and a RUN/TRAP FSM that turns an invalid instruction into a
// held trap request.
module id_ex_pipe_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  id_ex_pipe_ctrl_if.slave    bus,
  output logic                dbg_state   // 0 = RUN, 1 = TRAP
);

  typedef enum logic { ST_RUN = 1'b0, ST_TRAP = 1'b1 } state_e;
  typedef enum logic [1:0] { LD_LOAD, LD_HOLD, LD_BUBBLE } ld_e;

  state_e state_q, state_d;
  ld_e    ld_sel;
  logic   hazard;
  logic   take_trap;

  // Load in EX whose destination is read by the ID instruction; x0 never hazards.
  always_comb begin
    hazard = (state_q == ST_RUN) && bus.id_valid && bus.ex_valid && bus.ex_mem_read &&
             (bus.ex_rd_addr != '0) &&
             ((bus.ex_rd_addr == bus.id_rs1_addr) || (bus.ex_rd_addr == bus.id_rs2_addr)) &&
             !bus.stall_ext;
  end

  assign bus.load_use_stall = hazard;

  // An invalid instruction that would otherwise be loaded normally raises the trap.
  always_comb begin
    take_trap = (state_q == ST_RUN) && !bus.flush && !bus.stall_ext && !hazard &&
                bus.id_valid && bus.id_invalid_inst;
  end

  // Per-edge action on the ID/EX register: flush > stall > trap > hazard > load.
  always_comb begin
    ld_sel = LD_LOAD;
    if (bus.flush)                               ld_sel = LD_BUBBLE;
    else if (bus.stall_ext)                      ld_sel = LD_HOLD;
    else if (state_q == ST_TRAP)                 ld_sel = LD_BUBBLE;
    else if (hazard)                             ld_sel = LD_BUBBLE;
    else if (bus.id_valid && bus.id_invalid_inst) ld_sel = LD_BUBBLE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: flush cancels a trap ahead of trap_ack; ack works under stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (take_trap) state_d = ST_TRAP;
      ST_TRAP: if (bus.flush || bus.trap_ack) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: trap_req is a direct decode of the state flop.
  always_comb begin
    bus.trap_req = (state_q == ST_TRAP);
    dbg_state    = state_q;
  end

  // Capture the PC of the offending instruction when the trap is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         bus.trap_pc <= '0;
    else if (take_trap) bus.trap_pc <= bus.id_pc;
  end

  // ID/EX register: bubbles clear control only, data fields keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid          <= 1'b0;
      bus.ex_pc             <= '0;
      bus.ex_rs1_addr       <= '0;
      bus.ex_rs2_addr       <= '0;
      bus.ex_rd_addr        <= '0;
      bus.ex_rs1_data       <= '0;
      bus.ex_rs2_data       <= '0;
      bus.ex_imm            <= '0;
      bus.ex_func3          <= '0;
      bus.ex_func7          <= '0;
      bus.ex_alu_src        <= 1'b0;
      bus.ex_mem_write      <= 1'b0;
      bus.ex_mem_load_type  <= '0;
      bus.ex_mem_store_type <= '0;
      bus.ex_mem_read       <= 1'b0;
      bus.ex_wb_reg_file    <= 1'b0;
    end else begin
      case (ld_sel)
        LD_LOAD: begin
          bus.ex_valid          <= bus.id_valid;
          bus.ex_pc             <= bus.id_pc;
          bus.ex_rs1_addr       <= bus.id_rs1_addr;
          bus.ex_rs2_addr       <= bus.id_rs2_addr;
          bus.ex_rd_addr        <= bus.id_rd_addr;
          bus.ex_rs1_data       <= bus.id_rs1_data;
          bus.ex_rs2_data       <= bus.id_rs2_data;
          bus.ex_imm            <= bus.id_imm;
          bus.ex_func3          <= bus.id_func3;
          bus.ex_func7          <= bus.id_func7;
          bus.ex_alu_src        <= bus.id_valid ? bus.id_alu_src        : 1'b0;
          bus.ex_mem_write      <= bus.id_valid ? bus.id_mem_write      : 1'b0;
          bus.ex_mem_load_type  <= bus.id_valid ? bus.id_mem_load_type  : 3'b000;
          bus.ex_mem_store_type <= bus.id_valid ? bus.id_mem_store_type : 2'b00;
          bus.ex_mem_read       <= bus.id_valid ? bus.id_mem_read       : 1'b0;
          bus.ex_wb_reg_file    <= bus.id_valid ? bus.id_wb_reg_file    : 1'b0;
        end
        LD_BUBBLE: begin
          bus.ex_valid          <= 1'b0;
          bus.ex_alu_src        <= 1'b0;
          bus.ex_mem_write      <= 1'b0;
          bus.ex_mem_load_type  <= '0;
          bus.ex_mem_store_type <= '0;
          bus.ex_mem_read       <= 1'b0;
          bus.ex_wb_reg_file    <= 1'b0;
        end
        default: ;  // LD_HOLD: keep everything
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// Bench for id_ex_pipe_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level reference model of the stage rules.
module tb_id_ex_pipe_ctrl;

  localparam logic [1:0] STORE_SW = 2'b10;
  localparam logic [2:0] LOAD_LW  = 3'b010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;
  always #5 clk = ~clk;

  id_ex_pipe_ctrl_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  id_ex_pipe_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alu, mw;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic        mr, wb;
    logic        trap;
    logic [31:0] tpc;
  } snap_t;

  localparam int W = $bits(snap_t);
  logic [W-1:0] exp_q[$];
  snap_t m;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The stall rule: a load in EX with non-zero rd that ID reads, outside TRAP and stall_ext.
  function automatic logic model_lus();
    return !m.trap && bus.id_valid && m.valid && m.mr && (m.rd != 5'd0) &&
           ((m.rd == bus.id_rs1_addr) || (m.rd == bus.id_rs2_addr)) && !bus.stall_ext;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    snap_t n;
    logic  lus, do_load, do_bubble;
    n = m;
    lus = model_lus();
    do_load = 1'b0;
    do_bubble = 1'b0;
    if (bus.flush) do_bubble = 1'b1;
    else if (bus.stall_ext) ;
    else if (m.trap || lus || (bus.id_valid && bus.id_invalid_inst)) do_bubble = 1'b1;
    else do_load = 1'b1;

    if (do_load) begin
      n.valid = bus.id_valid;
      n.pc = bus.id_pc; n.rs1 = bus.id_rs1_addr; n.rs2 = bus.id_rs2_addr; n.rd = bus.id_rd_addr;
      n.d1 = bus.id_rs1_data; n.d2 = bus.id_rs2_data; n.imm = bus.id_imm;
      n.f3 = bus.id_func3; n.f7 = bus.id_func7;
      n.alu = bus.id_alu_src & bus.id_valid;
      n.mw  = bus.id_mem_write & bus.id_valid;
      n.lt  = bus.id_valid ? bus.id_mem_load_type : 3'd0;
      n.st  = bus.id_valid ? bus.id_mem_store_type : 2'd0;
      n.mr  = bus.id_mem_read & bus.id_valid;
      n.wb  = bus.id_wb_reg_file & bus.id_valid;
    end
    if (do_bubble) begin
      n.valid = 0; n.alu = 0; n.mw = 0; n.lt = 0; n.st = 0; n.mr = 0; n.wb = 0;
    end

    if (m.trap) begin
      if (bus.flush || bus.trap_ack) n.trap = 1'b0;
    end else if (!bus.flush && !bus.stall_ext && !lus && bus.id_valid && bus.id_invalid_inst) begin
      n.trap = 1'b1;
      n.tpc  = bus.id_pc;
    end
    m = n;
  endtask

  task automatic compare_outputs();
    snap_t e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
    check("ex_pc",    bus.ex_pc, e.pc);
    check("ex_rs1",   32'(bus.ex_rs1_addr), 32'(e.rs1));
    check("ex_rs2",   32'(bus.ex_rs2_addr), 32'(e.rs2));
    check("ex_rd",    32'(bus.ex_rd_addr), 32'(e.rd));
    check("ex_d1",    bus.ex_rs1_data, e.d1);
    check("ex_d2",    bus.ex_rs2_data, e.d2);
    check("ex_imm",   bus.ex_imm, e.imm);
    check("ex_func",  32'({bus.ex_func7, bus.ex_func3}), 32'({e.f7, e.f3}));
    check("ex_ctrl",  32'({bus.ex_alu_src, bus.ex_mem_write, bus.ex_mem_load_type,
                           bus.ex_mem_store_type, bus.ex_mem_read, bus.ex_wb_reg_file}),
                      32'({e.alu, e.mw, e.lt, e.st, e.mr, e.wb}));
    check("trap_req", 32'(bus.trap_req), 32'(e.trap));
    check("dbg_state", 32'(dbg_state), 32'(e.trap));
    check("trap_pc",  bus.trap_pc, e.tpc);
  endtask

  // One clock: check the combinational stall, step the model at the edge, check outputs.
  // Entered and left just after a falling edge.
  task automatic cycle();
    #1 check("load_use_stall", 32'(bus.load_use_stall), 32'(model_lus()));
    @(posedge clk);
    model_step();
    exp_q.push_back(m);
    #1 compare_outputs();
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic set_idle();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_func3 = 0; bus.id_func7 = 0;
    bus.id_alu_src = 0; bus.id_mem_write = 0; bus.id_mem_load_type = 0; bus.id_mem_store_type = 0;
    bus.id_mem_read = 0; bus.id_wb_reg_file = 0; bus.id_invalid_inst = 0;
    bus.flush = 0; bus.stall_ext = 0; bus.trap_ack = 0;
  endtask

  task automatic set_inst(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic mr, input logic [2:0] lt,
                          input logic mw, input logic [1:0] st, input logic wb, input logic inv);
    bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2;
    bus.id_rd_addr = rd; bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
    bus.id_imm = $urandom; bus.id_func3 = 3'($urandom_range(0, 7)); bus.id_func7 = 7'd0;
    bus.id_alu_src = mr | mw; bus.id_mem_read = mr; bus.id_mem_load_type = lt;
    bus.id_mem_write = mw; bus.id_mem_store_type = st; bus.id_wb_reg_file = wb;
    bus.id_invalid_inst = inv;
  endtask

  task automatic rand_inputs();
    bus.id_valid = ($urandom_range(0, 9) < 8);
    bus.id_pc = $urandom & 32'hffff_fffc;
    bus.id_rs1_addr = 5'($urandom_range(0, 3));
    bus.id_rs2_addr = 5'($urandom_range(0, 3));
    bus.id_rd_addr  = 5'($urandom_range(0, 3));
    bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
    bus.id_func3 = 3'($urandom_range(0, 7)); bus.id_func7 = 7'($urandom_range(0, 127));
    bus.id_alu_src = 1'($urandom_range(0, 1));
    bus.id_mem_read = ($urandom_range(0, 2) == 0);
    bus.id_mem_load_type = 3'($urandom_range(0, 7));
    bus.id_mem_write = 1'($urandom_range(0, 1));
    bus.id_mem_store_type = 2'($urandom_range(0, 3));
    bus.id_wb_reg_file = 1'($urandom_range(0, 1));
    bus.id_invalid_inst = ($urandom_range(0, 11) == 0);
    bus.flush = ($urandom_range(0, 11) == 0);
    bus.stall_ext = ($urandom_range(0, 5) == 0);
    bus.trap_ack = ($urandom_range(0, 3) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_idle();
    m = '0;
    repeat (2) @(negedge clk);
    exp_q.push_back(m);
    compare_outputs();
    rst_n = 1'b1;

    // lw x5,0(x1) ; add x6,x5,x2 -> one bubble, then add reaches EX
    set_inst(32'h10, 5'd1, 5'd0, 5'd5, 1'b1, LOAD_LW, 1'b0, 2'd0, 1'b1, 1'b0);
    cycle();
    set_inst(32'h14, 5'd5, 5'd2, 5'd6, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    #1 check("t2_stall_hi", 32'(bus.load_use_stall), 32'd1);
    cycle();
    check("t2_bubble", 32'(bus.ex_valid), 32'd0);
    #1 check("t2_stall_lo", 32'(bus.load_use_stall), 32'd0);
    cycle();
    check("t2_add_in_ex", 32'({bus.ex_valid, bus.ex_rd_addr}), 32'({1'b1, 5'd6}));

    // lw x0 then use of x0 -> no stall, no bubble
    set_inst(32'h18, 5'd1, 5'd0, 5'd0, 1'b1, LOAD_LW, 1'b0, 2'd0, 1'b1, 1'b0);
    cycle();
    set_inst(32'h1c, 5'd0, 5'd0, 5'd7, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    #1 check("t3_no_stall", 32'(bus.load_use_stall), 32'd0);
    cycle();
    check("t3_no_bubble", 32'(bus.ex_valid), 32'd1);

    // sw then stall_ext for 3 cycles -> EX contents held
    set_inst(32'h20, 5'd1, 5'd2, 5'd0, 1'b0, 3'd0, 1'b1, STORE_SW, 1'b0, 1'b0);
    bus.id_func3 = 3'b010;
    cycle();
    check("t4_store_type", 32'(bus.ex_mem_store_type), 32'(STORE_SW));
    set_inst(32'h24, 5'd3, 5'd3, 5'd3, 1'b1, LOAD_LW, 1'b0, 2'd0, 1'b1, 1'b0);
    bus.stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_held_pc", bus.ex_pc, 32'h20);
      check("t4_held_st", 32'({bus.ex_valid, bus.ex_mem_store_type}), 32'({1'b1, STORE_SW}));
    end
    bus.stall_ext = 1'b0;
    cycle();

    // invalid instruction at 0x100 -> trap held until trap_ack
    set_inst(32'h100, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    bus.id_func7 = 7'h7f;
    cycle();
    check("t5_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("t5_trap_req", 32'(bus.trap_req), 32'd1);
    check("t5_trap_pc", bus.trap_pc, 32'h100);
    set_inst(32'h104, 5'd1, 5'd1, 5'd1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    repeat (2) begin
      cycle();
      check("t5_trap_hold", 32'({bus.trap_req, bus.ex_valid}), 32'({1'b1, 1'b0}));
    end
    bus.trap_ack = 1'b1;
    cycle();
    check("t5_trap_clear", 32'(bus.trap_req), 32'd0);
    bus.trap_ack = 1'b0;

    // flush coincident with invalid instruction -> no trap
    set_inst(32'h200, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    bus.flush = 1'b1;
    cycle();
    check("t6_no_trap", 32'(bus.trap_req), 32'd0);
    check("t6_ex_valid", 32'(bus.ex_valid), 32'd0);
    bus.flush = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // asynchronous reset mid-run, checked before the next rising edge
    rand_inputs();
    #2 rst_n = 1'b0;
    #1;
    m = '0;
    exp_q.push_back(m);
    compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on simulated time in case anything above stops advancing.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by %0t", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
